// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Pure declarations; no logic, latency or flow control.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU opcode decode from the FSM's alu_op class plus instruction fields.
// Purely combinational, zero latency, no flow control.
module rv_alu_decoder
    import rv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type sub from I-type addi with imm[10] set
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM over one shared memory port; 3-5 cycles per instruction.
// Memory req is held until mem_ready, so any number of wait states is absorbed.
module rv_multicycle_ctrl
    import rv_mc_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] alu_op;
    logic       branch_ok;
    logic       retire;
    logic       mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;

    assign branch_ok = (funct3 == 3'b000) | (ENABLE_BNE && (funct3 == 3'b001));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = branch_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_nxt = S_JAL;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_TRAP;
        endcase
    end

    assign retire = (state == S_MEMWB) | (state == S_ALUWB) | (state == S_BRANCH) |
                    ((state == S_MEMWRITE) & mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire)
                instret <= instret + CNT_W'(1);
            if (state_nxt == S_TRAP)
                illegal <= 1'b1;
        end
    end

    // Defaults are the FETCH mux settings; TRAP falls through with all strobes low.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        alu_op      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_s  = 1'b1;
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src  = RES_MEMDATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write_s = zero ^ (ENABLE_BNE & funct3[0]);
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                result_src = RES_ALUOUT;
                pc_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    // Strobes drop the instant reset asserts, independent of the clock.
    assign mem_req   = mem_req_s   & ~rst;
    assign mem_write = mem_write_s & ~rst;
    assign ir_write  = ir_write_s  & ~rst;
    assign pc_write  = pc_write_s  & ~rst;
    assign reg_write = reg_write_s & ~rst;
    assign state_o   = state;

    rv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule
